// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: widths, reset PC, opcodes, instruction field
// positions and the entry record carried through the fetch buffer.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int OP_LSB     = 0;
    localparam int OP_MSB     = 6;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry in-order buffer: output register plus one skid slot behind it.
// space reports free entries after this cycle's pop, for the fetch issue rule.
module fetch_skid_buffer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output logic         out_valid,
    output fetch_entry_t out_data,
    output logic         skid_valid,
    output logic [1:0]   space
);

    fetch_entry_t skid_data;

    assign space = 2'd2 - {1'b0, out_valid} - {1'b0, skid_valid} + {1'b0, pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= '{instr: '0, pc: RESET_PC, pc_plus4: RESET_PC + 32'd4};
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (pop) begin
            // Older skid entry advances first so program order is kept.
            if (skid_valid) begin
                out_data   <= skid_data;
                skid_valid <= push;
                if (push) skid_data <= push_data;
            end else begin
                out_valid <= push;
                if (push) out_data <= push_data;
            end
        end else if (push) begin
            if (!out_valid) begin
                out_valid <= 1'b1;
                out_data  <= push_data;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= push_data;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem read in flight and hands
// instructions with pre-split fields to decode over valid/ready.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    // Handshake: a transfer happens in every cycle where instr_valid && dec_ready;
    // while instr_valid && !dec_ready all outputs hold their values.

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            inflight;
    logic            drop;
    logic            fire;
    logic            push;
    logic            out_valid;
    logic            skid_valid;
    logic [1:0]      space;
    fetch_entry_t    push_data;
    fetch_entry_t    out_data;

    assign fire      = out_valid && dec_ready;
    // A response still landing during a redirect belongs to the old path.
    assign push      = inflight && !drop && !redirect;
    assign push_data = '{instr: imem_rdata, pc: req_pc, pc_plus4: req_pc + 32'd4};
    assign imem_req  = !rst && !redirect && ({1'b0, inflight} < space);
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
            drop     <= 1'b0;
        end else begin
            inflight <= imem_req;
            drop     <= redirect && inflight;
            if (imem_req) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (redirect) fetch_pc <= redirect_pc & ~32'h3;
        end
    end

    fetch_skid_buffer #(.RESET_PC(RESET_PC)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .push       (push),
        .push_data  (push_data),
        .pop        (fire),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .skid_valid (skid_valid),
        .space      (space)
    );

    assign instr_valid = out_valid;
    assign instr       = out_data.instr;
    assign op          = out_data.instr[OP_MSB:OP_LSB];
    assign funct3      = out_data.instr[FUNCT3_MSB:FUNCT3_LSB];
    assign funct7      = out_data.instr[FUNCT7_MSB:FUNCT7_LSB];
    assign pc          = out_data.pc;
    assign pc_plus4    = out_data.pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall, redirects, PC wrap
// and reset while stalled, with an expected-PC queue checked on every handshake.
module tb_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst, redirect, dec_ready;
    logic [31:0] redirect_pc;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4;
    logic [6:0]  op, funct7;
    logic [2:0]  funct3;

    logic        rst_w;
    logic        w_imem_req, w_instr_valid;
    logic [31:0] w_imem_addr, w_imem_rdata, w_instr, w_pc, w_pc_plus4;
    logic [6:0]  w_op, w_funct7;
    logic [2:0]  w_funct3;

    int n_checks = 0;
    int n_errors = 0;
    int stall_reqs;
    logic wrap_done = 1'b0;
    logic [31:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .dec_ready(dec_ready), .instr(instr), .op(op),
        .funct3(funct3), .funct7(funct7), .pc(pc), .pc_plus4(pc_plus4)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst_w), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_rdata(w_imem_rdata), .redirect(1'b0), .redirect_pc(32'h0),
        .instr_valid(w_instr_valid), .dec_ready(1'b1), .instr(w_instr), .op(w_op),
        .funct3(w_funct3), .funct7(w_funct7), .pc(w_pc), .pc_plus4(w_pc_plus4)
    );

    // synchronous instruction memories: data = addr ^ K one cycle after the request
    always @(posedge clk) begin
        imem_rdata   <= imem_req   ? (imem_addr ^ K)   : 32'hDEAD_BEEF;
        w_imem_rdata <= w_imem_req ? (w_imem_addr ^ K) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // scoreboard: every handshake must match the next expected PC and its word
    always @(negedge clk) begin
        if (!rst && instr_valid && dec_ready) begin
            check("fire_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                logic [31:0] e_pc, e_instr;
                e_pc    = exp_q.pop_front();
                e_instr = e_pc ^ K;
                check("fire_pc", pc, e_pc);
                check("fire_instr", instr, e_instr);
                check("fire_pc_plus4", pc_plus4, e_pc + 32'd4);
                check("fire_op", 32'(op), 32'(e_instr[6:0]));
                check("fire_funct3", 32'(funct3), 32'(e_instr[14:12]));
                check("fire_funct7", 32'(funct7), 32'(e_instr[31:25]));
            end
        end
    end

    // driver helper: advance into the next cycle and settle inputs
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // PC wrap instance
    initial begin
        rst_w = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_w = 1'b0;
        @(negedge clk); check("w_addr_c0", w_imem_addr, 32'hFFFF_FFF8);
        next_cycle();
        @(negedge clk); check("w_addr_c1", w_imem_addr, 32'hFFFF_FFFC);
        next_cycle();
        @(negedge clk);
        check("w_addr_c2", w_imem_addr, 32'h0000_0000);
        check("w_valid_c2", 32'(w_instr_valid), 32'd1);
        check("w_pc_c2", w_pc, 32'hFFFF_FFF8);
        check("w_pc4_c2", w_pc_plus4, 32'hFFFF_FFFC);
        next_cycle();
        @(negedge clk);
        check("w_pc_c3", w_pc, 32'hFFFF_FFFC);
        check("w_pc4_c3", w_pc_plus4, 32'h0000_0000);
        next_cycle();
        @(negedge clk);
        check("w_pc_c4", w_pc, 32'h0000_0000);
        check("w_instr_c4", w_instr, K);
        wrap_done = 1'b1;
    end

    initial begin
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C,
                  32'h100, 32'h200, 32'h204, 32'h208, 32'h20C,
                  32'h3A4C, 32'h3A50, 32'h0, 32'h4};
        rst = 1'b1; dec_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_pc4", pc_plus4, 32'h4);
        check("rst_fields", {18'h0, op, funct3, funct7}, 32'h0);

        next_cycle(); rst = 1'b0;                                   // cycle 0
        @(negedge clk);
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", imem_addr, 32'h0);
        check("c0_valid", 32'(instr_valid), 32'd0);
        next_cycle();                                               // cycle 1
        @(negedge clk);
        check("c1_valid", 32'(instr_valid), 32'd0);
        check("c1_addr", imem_addr, 32'h4);
        next_cycle();                                               // cycle 2
        @(negedge clk);
        check("c2_valid", 32'(instr_valid), 32'd1);
        check("c2_pc", pc, 32'h0);
        next_cycle();                                               // cycle 3
        next_cycle();                                               // cycle 4
        @(negedge clk);
        check("c4_req", 32'(imem_req), 32'd1);
        check("c4_addr", imem_addr, 32'h10);
        check("c4_pc", pc, 32'h8);

        stall_reqs = 0;
        for (int i = 0; i < 5; i++) begin                           // cycles 5..9
            next_cycle(); dec_ready = 1'b0;
            @(negedge clk);
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_pc", pc, 32'hC);
            if (imem_req) stall_reqs++;
        end
        check("stall_reqs", 32'(stall_reqs), 32'd0);

        next_cycle(); dec_ready = 1'b1;                             // cycle 10
        @(negedge clk);
        check("c10_pc", pc, 32'hC);
        check("c10_req", 32'(imem_req), 32'd1);
        check("c10_addr", imem_addr, 32'h14);
        next_cycle(); @(negedge clk); check("c11_pc", pc, 32'h10);
        next_cycle(); @(negedge clk); check("c12_pc", pc, 32'h14);
        next_cycle(); @(negedge clk); check("c13_pc", pc, 32'h18);

        next_cycle(); redirect = 1'b1; redirect_pc = 32'h100;       // cycle 14 = t
        @(negedge clk);
        check("t_req", 32'(imem_req), 32'd0);
        check("t_pc", pc, 32'h1C);
        next_cycle(); redirect = 1'b0;                              // t+1
        @(negedge clk);
        check("t1_req", 32'(imem_req), 32'd1);
        check("t1_addr", imem_addr, 32'h100);
        check("t1_valid", 32'(instr_valid), 32'd0);
        next_cycle(); @(negedge clk); check("t2_valid", 32'(instr_valid), 32'd0);
        next_cycle(); @(negedge clk);                               // t+3 = 17
        check("t3_valid", 32'(instr_valid), 32'd1);
        check("t3_pc", pc, 32'h100);

        next_cycle(); dec_ready = 1'b0;                             // 18
        next_cycle();                                               // 19
        next_cycle(); redirect = 1'b1; redirect_pc = 32'h203;       // 20
        @(negedge clk);
        check("c20_pc", pc, 32'h104);
        check("c20_req", 32'(imem_req), 32'd0);
        next_cycle(); redirect = 1'b0; dec_ready = 1'b1;            // 21
        @(negedge clk);
        check("c21_addr", imem_addr, 32'h200);
        check("c21_valid", 32'(instr_valid), 32'd0);
        next_cycle();                                               // 22
        next_cycle(); @(negedge clk);                               // 23
        check("c23_pc", pc, 32'h200);
        next_cycle(); next_cycle();                                 // 24, 25
        next_cycle(); redirect = 1'b1; redirect_pc = 32'h3A4F;      // 26
        next_cycle(); redirect = 1'b0;                              // 27
        @(negedge clk);
        check("c27_addr", imem_addr, 32'h3A4C);
        next_cycle(); next_cycle();                                 // 28, 29
        next_cycle();                                               // 30
        next_cycle(); dec_ready = 1'b0;                             // 31
        next_cycle();                                               // 32
        @(negedge clk);
        check("c32_pc", pc, 32'h3A54);
        check("c32_req", 32'(imem_req), 32'd0);
        next_cycle(); rst = 1'b1;                                   // 33
        next_cycle(); rst = 1'b0; dec_ready = 1'b1;                 // 34
        @(negedge clk);
        check("c34_valid", 32'(instr_valid), 32'd0);
        check("c34_req", 32'(imem_req), 32'd1);
        check("c34_addr", imem_addr, 32'h0);
        next_cycle(); @(negedge clk); check("c35_valid", 32'(instr_valid), 32'd0);
        next_cycle(); @(negedge clk);                               // 36
        check("c36_valid", 32'(instr_valid), 32'd1);
        check("c36_pc", pc, 32'h0);
        next_cycle();                                               // 37
        next_cycle(); dec_ready = 1'b0;                             // 38
        @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        for (int i = 0; i < 50 && !wrap_done; i++) @(negedge clk);
        check("wrap_done", 32'(wrap_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
